// File: rtl/mac_apot_vec_if.sv
// Beat input and result output handshake bundle for mac_apot_vec.
// The engine sits on the slave side; the beat producer and result consumer sit on the master side.
interface mac_apot_vec_if #(
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8
);
  logic                        in_valid;
  logic                        in_ready;
  logic [4*LANES-1:0]          act;
  logic [4*LANES-1:0]          weight;
  logic [LEN_WIDTH-1:0]        len;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_sat;

  modport slave (
    input  in_valid, act, weight, len, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output in_valid, act, weight, len, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_apot_vec.sv
// Multi-lane APoT multiply-accumulate engine.
// Each beat carries LANES 4-bit APoT activation/weight pairs; the beat dot product
// is accumulated over a programmable group length and one (optionally saturated)
// result per group is offered on a valid/ready output. A single enable freezes the
// whole three-stage pipeline while a result is held by the consumer.
module mac_apot_vec #(
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8,
  parameter bit SATURATE  = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mac_apot_vec_if.slave s_if
);

  localparam int SUM_W  = 9 + $clog2(LANES);
  localparam int WIDE_W = ACC_WIDTH + 2;

  // APoT magnitude: bits[2:1] pick the large term, bit0 adds 2.
  function automatic logic [3:0] apot_mag(input logic [3:0] code);
    logic [3:0] t1;
    case (code[2:1])
      2'b00:   t1 = 4'd0;
      2'b01:   t1 = 4'd8;
      2'b10:   t1 = 4'd4;
      default: t1 = 4'd1;
    endcase
    return t1 + (code[0] ? 4'd2 : 4'd0);
  endfunction

  // Signed 9-bit lane product; a negative-zero code still yields 0.
  function automatic logic signed [8:0] lane_prod(input logic [3:0] a, input logic [3:0] w);
    logic [7:0] mag;
    mag = {4'd0, apot_mag(a)} * {4'd0, apot_mag(w)};
    return (a[3] ^ w[3]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // True when the widened sum no longer fits ACC_WIDTH and clamping is enabled.
  function automatic logic ovf_of(input logic signed [WIDE_W-1:0] v);
    logic [2:0] top;
    top = v[WIDE_W-1:ACC_WIDTH-1];
    return SATURATE && (top != 3'b000) && (top != 3'b111);
  endfunction

  // Clamp to the signed ACC_WIDTH range, or wrap when clamping is disabled.
  function automatic logic signed [ACC_WIDTH-1:0] sat_fit(input logic signed [WIDE_W-1:0] v);
    if (ovf_of(v)) begin
      return v[WIDE_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return v[ACC_WIDTH-1:0];
  endfunction

  logic                        en;
  logic                        accept;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [LEN_WIDTH-1:0]        eff_len;
  logic                        last_beat;

  logic                        vld_p1_q;
  logic                        last_p1_q;
  logic [4*LANES-1:0]          act_p1_q;
  logic [4*LANES-1:0]          wt_p1_q;

  logic signed [SUM_W-1:0]     beat_sum;
  logic                        vld_p2_q;
  logic                        last_p2_q;
  logic signed [SUM_W-1:0]     sum_p2_q;

  logic signed [WIDE_W-1:0]    acc_wide;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        acc_ovf;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        sat_flag_q;
  logic                        out_valid_q;
  logic signed [ACC_WIDTH-1:0] out_data_q;
  logic                        out_sat_q;

  assign en     = !out_valid_q || s_if.out_ready;
  assign accept = s_if.in_valid && en;

  assign s_if.in_ready  = en;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = out_data_q;
  assign s_if.out_sat   = out_sat_q;

  // Group bookkeeping: latch the length on a group's first beat and flag its last beat.
  always_comb begin
    eff_len   = len_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    if (cnt_q == '0) begin
      eff_len = (s_if.len == '0) ? LEN_WIDTH'(1) : s_if.len;
    end
    last_beat = (cnt_q == eff_len - LEN_WIDTH'(1));
    if (accept) begin
      len_d = eff_len;
      cnt_d = last_beat ? '0 : cnt_q + LEN_WIDTH'(1);
    end
  end

  // Beat sum of all lane products for the operands held in stage 1.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + SUM_W'(lane_prod(act_p1_q[4*i +: 4], wt_p1_q[4*i +: 4]));
    end
  end

  // Accumulator update candidate, widened so both clamp and wrap are exact.
  always_comb begin
    acc_wide = WIDE_W'(acc_q) + WIDE_W'(sum_p2_q);
    acc_next = sat_fit(acc_wide);
    acc_ovf  = ovf_of(acc_wide);
  end

  // Control state: beat counter, latched length and per-stage valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      len_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en) begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage 1 / stage 2 boundary: operand capture, then decoded beat sum ----
  always_ff @(posedge clk) begin
    if (en) begin
      act_p1_q  <= s_if.act;
      wt_p1_q   <= s_if.weight;
      last_p1_q <= last_beat;
      sum_p2_q  <= beat_sum;
      last_p2_q <= last_p1_q;
    end
  end

  // ---- stage 3: accumulate, close the group on its last beat, run the output handshake ----
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      if (vld_p2_q && last_p2_q) begin
        out_data_q  <= acc_next;
        out_sat_q   <= sat_flag_q | acc_ovf;
        out_valid_q <= 1'b1;
        acc_q       <= '0;
        sat_flag_q  <= 1'b0;
      end else begin
        if (vld_p2_q) begin
          acc_q      <= acc_next;
          sat_flag_q <= sat_flag_q | acc_ovf;
        end
        if (s_if.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_apot_vec.sv
// Bench for mac_apot_vec: three engines (20-bit clamping, 10-bit clamping, 10-bit
// wrapping) share one beat stream; results are checked against a group-level
// arithmetic model plus directed expectations.
module tb_mac_apot_vec;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] act = '0;
  logic [15:0] weight = '0;
  logic [7:0]  len = '0;
  logic        out_ready = 1'b1;
  bit          rand_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_apot_vec_if #(.LANES(4), .ACC_WIDTH(20), .LEN_WIDTH(8)) if0 ();
  mac_apot_vec_if #(.LANES(4), .ACC_WIDTH(10), .LEN_WIDTH(8)) if1 ();
  mac_apot_vec_if #(.LANES(4), .ACC_WIDTH(10), .LEN_WIDTH(8)) if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.act = act;            assign if1.act = act;            assign if2.act = act;
  assign if0.weight = weight;      assign if1.weight = weight;      assign if2.weight = weight;
  assign if0.len = len;            assign if1.len = len;            assign if2.len = len;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  mac_apot_vec #(.LANES(4), .ACC_WIDTH(20), .LEN_WIDTH(8), .SATURATE(1'b1)) u_a20 (
    .clk(clk), .reset(reset), .s_if(if0.slave));
  mac_apot_vec #(.LANES(4), .ACC_WIDTH(10), .LEN_WIDTH(8), .SATURATE(1'b1)) u_s10 (
    .clk(clk), .reset(reset), .s_if(if1.slave));
  mac_apot_vec #(.LANES(4), .ACC_WIDTH(10), .LEN_WIDTH(8), .SATURATE(1'b0)) u_w10 (
    .clk(clk), .reset(reset), .s_if(if2.slave));

  // ---------------- reference model ----------------
  int     grp_rem = 0;
  longint grp_sums[$];
  longint qd0[$], qd1[$], qd2[$];
  bit     qs0[$], qs1[$], qs2[$];

  function automatic int apot_val(input logic [3:0] c);
    int big[4];
    int m;
    big = '{0, 8, 4, 1};
    m = big[c[2:1]] + (c[0] ? 2 : 0);
    return c[3] ? -m : m;
  endfunction

  function automatic longint beat_value(input logic [15:0] a, input logic [15:0] w);
    longint s = 0;
    for (int i = 0; i < 4; i++) s += longint'(apot_val(a[4*i +: 4]) * apot_val(w[4*i +: 4]));
    return s;
  endfunction

  function automatic void fold(input int wb, input bit sat_en, output longint res, output bit ovf);
    longint hi, lo, span, acc;
    span = longint'(1) << wb;
    hi = (longint'(1) << (wb - 1)) - 1;
    lo = -(longint'(1) << (wb - 1));
    acc = 0;
    ovf = 1'b0;
    foreach (grp_sums[i]) begin
      acc += grp_sums[i];
      if (sat_en) begin
        if (acc > hi) begin acc = hi; ovf = 1'b1; end
        else if (acc < lo) begin acc = lo; ovf = 1'b1; end
      end else begin
        acc = acc & (span - 1);
        if (acc > hi) acc -= span;
      end
    end
    res = acc;
  endfunction

  task automatic model_accept(input logic [15:0] a, input logic [15:0] w, input logic [7:0] l);
    longint r;
    bit o;
    if (grp_rem == 0) grp_rem = (l == 0) ? 1 : int'(l);
    grp_sums.push_back(beat_value(a, w));
    grp_rem--;
    if (grp_rem == 0) begin
      fold(20, 1'b1, r, o); qd0.push_back(r); qs0.push_back(o);
      fold(10, 1'b1, r, o); qd1.push_back(r); qs1.push_back(o);
      fold(10, 1'b0, r, o); qd2.push_back(r); qs2.push_back(o);
      grp_sums.delete();
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(if0.in_ready), 1);
    chk({tag, "_out_valid"}, 64'(if0.out_valid), 0);
    chk({tag, "_out_data"}, 64'(if0.out_data), 0);
    chk({tag, "_out_sat"}, 64'(if0.out_sat), 0);
    chk({tag, "_s10_valid"}, 64'(if1.out_valid), 0);
    chk({tag, "_w10_data"}, 64'(if2.out_data), 0);
  endtask

  // Scoreboard: every consumed result must match the model, in order.
  always @(negedge clk) begin
    if (!reset && if0.out_valid && out_ready) begin
      chk("valid_agree", 64'({if1.out_valid, if2.out_valid}), 2'b11);
      chk("result_expected", 64'(qd0.size() != 0), 1);
      if (qd0.size() != 0) begin
        chk("sb_data_a20", 64'(if0.out_data), qd0.pop_front());
        chk("sb_sat_a20", 64'(if0.out_sat), 64'(qs0.pop_front()));
        chk("sb_data_s10", 64'(if1.out_data), qd1.pop_front());
        chk("sb_sat_s10", 64'(if1.out_sat), 64'(qs1.pop_front()));
        chk("sb_data_w10", 64'(if2.out_data), qd2.pop_front());
        chk("sb_sat_w10", 64'(if2.out_sat), 64'(qs2.pop_front()));
      end
    end
  end

  // Present one beat until accepted; call and return one time unit after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] w, input logic [7:0] l);
    int guard = 0;
    in_valid = 1'b1; act = a; weight = w; len = l;
    while (1) begin
      @(negedge clk);
      if (if0.in_ready) begin
        model_accept(a, w, l);
        @(posedge clk); #1;
        break;
      end
      guard++;
      if (guard > 200) begin
        chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_result(input string tag, input longint e0, input longint e1, input longint e2,
                               input bit s0, input bit s1, input bit s2);
    int n = 0;
    @(negedge clk);
    while (!if0.out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, 64'(if0.out_valid), 1);
    chk({tag, "_a20"}, 64'(if0.out_data), e0);
    chk({tag, "_s10"}, 64'(if1.out_data), e1);
    chk({tag, "_w10"}, 64'(if2.out_data), e2);
    chk({tag, "_sat_a20"}, 64'(if0.out_sat), 64'(s0));
    chk({tag, "_sat_s10"}, 64'(if1.out_sat), 64'(s1));
    chk({tag, "_sat_w10"}, 64'(if2.out_sat), 64'(s2));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    // Reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;

    // Basic dot product with latency
    out_ready = 1'b1;
    send(16'h3333, 16'h3333, 8'd1);
    @(negedge clk); chk("lat_c1", 64'(if0.out_valid), 0);
    @(negedge clk); chk("lat_c2", 64'(if0.out_valid), 0);
    @(negedge clk); chk("lat_c3", 64'(if0.out_valid), 1);
    chk("basic_data", 64'(if0.out_data), 400);
    chk("basic_sat", 64'(if0.out_sat), 0);
    @(posedge clk); #1;

    // Decode sweep on lane 0, back to back
    for (int c = 0; c < 256; c++) send(16'(c >> 4), 16'(c & 15), 8'd1);
    repeat (6) @(posedge clk); #1;
    send(16'h000B, 16'h0003, 8'd1); expect_result("dec_m100", -100, -100, -100, 0, 0, 0);
    send(16'h0006, 16'h0004, 8'd1); expect_result("dec_p4", 4, 4, 4, 0, 0, 0);
    send(16'h0008, 16'h0003, 8'd1); expect_result("dec_negzero", 0, 0, 0, 0, 0, 0);

    // Grouping, len ignored mid-group, len=0 treated as 1
    send(16'h3333, 16'h3333, 8'd3);
    send(16'h3333, 16'hBBBB, 8'd7);
    send(16'h3333, 16'h3333, 8'd0);
    expect_result("group3", 400, 400, 400, 0, 0, 0);
    send(16'h3333, 16'h3333, 8'd0);
    expect_result("len0", 400, 400, 400, 0, 0, 0);

    // Backpressure
    out_ready = 1'b0;
    send(16'h3333, 16'h3333, 8'd1);
    send(16'h3333, 16'hBBBB, 8'd1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_hold_valid", 64'(if0.out_valid), 1);
    chk("bp_in_ready_low", 64'(if0.in_ready), 0);
    chk("bp_hold_data", 64'(if0.out_data), 400);
    repeat (3) @(negedge clk);
    chk("bp_still_data", 64'(if0.out_data), 400);
    chk("bp_still_in_ready", 64'(if0.in_ready), 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_data", 64'(if0.out_data), 400);
    @(negedge clk);
    chk("bp_second_valid", 64'(if0.out_valid), 1);
    chk("bp_second_data", 64'(if0.out_data), -400);
    @(posedge clk); #1;

    // Saturation / wrap, then a clean group
    send(16'h3333, 16'h3333, 8'd2);
    send(16'h3333, 16'h3333, 8'd2);
    expect_result("sat", 800, 511, -224, 0, 1, 0);
    send(16'h000B, 16'h0003, 8'd1);
    expect_result("after_sat", -100, -100, -100, 0, 0, 0);

    // Reset in the middle of a group
    send(16'h3333, 16'h3333, 8'd4);
    send(16'h3333, 16'h3333, 8'd4);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    grp_rem = 0;
    grp_sums.delete();
    @(negedge clk);
    check_reset("midreset");
    @(posedge clk); #1;
    send(16'h0003, 16'h0003, 8'd1);
    expect_result("post_reset", 100, 100, 100, 0, 0, 0);

    // Randomized beats, lengths and consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(16'($urandom), 16'($urandom), 8'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (qd0.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain_a20", 64'(qd0.size()), 0);
    chk("drain_s10", 64'(qd1.size()), 0);
    chk("drain_w10", 64'(qd2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_apot_vec.md
# mac_apot_vec

Multi-lane, pipelined multiply-accumulate engine for 4-bit APoT (additive powers-of-two) weights and activations. It computes a dot product over `LANES` operand pairs per beat and accumulates across a runtime-programmable number of beats. It emits one saturated result per group over a valid/ready output handshake. It is the vector successor of the single-lane APoT MAC, adding lanes, grouping, backpressure and saturation.

## Interface
- `LANES`, 4: operand pairs per beat; must be ≥1.
- `ACC_WIDTH`, 20: accumulator and result width, signed; must be ≥ 8+clog2(LANES).
- `LEN_WIDTH`, 8: width of the group-length input.
- `SATURATE`, 1: 1 clamps the accumulator, 0 lets it wrap (two's complement).

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; clock clk
- `in_valid`  in  1  a beat is presented
- `in_ready`  out  1  a beat is accepted this cycle when in_valid && in_ready
- `act`  in  4*LANES  activation codes; lane i is bits [4i+3:4i]
- `weight`  in  4*LANES  weight codes, same packing
- `len`  in  LEN_WIDTH  beats per group; sampled only on the first beat of a group; 0 is treated as 1
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  ACC_WIDTH  signed dot-product result
- `out_sat`  out  1  saturation occurred anywhere in this group (always 0 when SATURATE=0)

## Operation
- **Code decode:** bit3 is the sign; magnitude = T1 + (bit0 ? 2 : 0), where bits[2:1] select T1: 00→0, 01→8, 10→4, 11→1.
  - The resulting magnitude set is {0,1,2,3,4,6,8,10}.
  - Code 1000 (negative zero) yields 0.
- **Lane product:** sign = a[3]^w[3], magnitude = |a|·|w| (at most 100), converted to 9-bit two's complement.
- **Beat sum:** signed sum of all lane products, width 9+clog2(LANES), sign-extended to ACC_WIDTH.
- **Pipeline:** S1 registers the operands plus a last flag. S2 registers the decoded, multiplied and summed beat. S3 is the accumulator and output register. Each stage carries its own valid bit; invalid stages do not touch the accumulator.
- **Global advance:** `en = !out_valid || out_ready`. All stages advance only when en=1, and `in_ready = en`.
- **Beat counter `cnt`:** increments on each accepted beat.
  - When cnt==0, the beat latches `len` (0→1).
  - The beat is flagged last when cnt == latched_len−1, and the counter then returns to 0.
- **S3 on a valid, non-last beat:** acc ← f(acc + sum); sat_flag ← sat_flag | overflow.
- **S3 on a valid, last beat:** out_data ← f(acc + sum); out_sat ← sat_flag | overflow; out_valid ← 1; acc ← 0; sat_flag ← 0.
- **f:** with SATURATE=1, clamps to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]; otherwise wraps.
- **Output handshake:**
  - When out_valid && out_ready and no new result arrives, out_valid ← 0.
  - When a new result arrives in the same cycle as the handshake, it loads and out_valid stays 1.
  - out_data and out_sat are stable while out_valid && !out_ready.

## Timing
- **Reset values:** in_ready=1 (from the cycle after reset), out_valid=0, out_data=0, out_sat=0; acc, cnt, latched_len, sat_flag and all stage valids are 0.
- **Latency:** a last beat handshaken in cycle c gives out_valid=1 in cycle c+3 when no stall occurs. Throughput is one beat per cycle.
- **Stall:** while out_valid && !out_ready, in_ready=0 and the pipeline is frozen. No beat is lost or duplicated, and results appear in order.
- **Reset mid-group:** the partial sum and all in-flight beats are discarded, and the next accepted beat starts a new group.
- **Back-to-back groups:** the first beat of the next group may be accepted in the cycle after the previous group's last beat. acc is cleared by the last beat itself, so no bubble is required.
- **`len` changes mid-group:** ignored until the next group.

## Test plan
- **Basic dot product:** LANES=4, len=1, all act=0011 (+10), all weight=0011 → out_data=400 at c+3, out_sat=0.
- **Decode sweep:** lane 0 sweeps all 256 (act, weight) code pairs, other lanes 0, len=1.
  - out_data must equal the signed table product, e.g. 1011×0011 → −100, 0110×0100 (+1 × +4) → 4, 1000×0011 → 0.
- **Grouping:** len=3 with beat sums +400, −400 (weight=1011), +400 → a single result of 400. Then a len=0 beat of sum 400 → 400.
- **Backpressure:** two len=1 groups (400, then −400) with out_ready=0 for 5 cycles.
  - in_ready drops while the first result is held.
  - When out_ready=1 is released, 400 then −400 are delivered with no loss.
- **Saturation (ACC_WIDTH=10):** len=2, beats of 400 each → out_data=511, out_sat=1. The next group (len=1, sum −100) → −100, out_sat=0. With SATURATE=0 the first result is −224.
- **Reset mid-group:** len=4, reset after 2 beats → outputs are at reset values. Then len=1, sum 100 → 100.
